// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter driving a simple single-cycle memory bus.
// Writes occupy one ISSUE cycle; reads add a CAPTURE cycle and return data on read_valid_i.
module bus_arbiter #(
   parameter int unsigned ADDRESS_WIDTH = 8,
   parameter int unsigned DATA_WIDTH    = 8
) (
   input  logic                     clock,
   input  logic                     reset,

   input  logic                     request_0,
   input  logic [ADDRESS_WIDTH-1:0] address_0,
   input  logic                     write_enable_0,
   input  logic [DATA_WIDTH-1:0]    write_data_0,
   output logic                     grant_0,
   output logic                     read_valid_0,
   output logic [DATA_WIDTH-1:0]    read_data_0,

   input  logic                     request_1,
   input  logic [ADDRESS_WIDTH-1:0] address_1,
   input  logic                     write_enable_1,
   input  logic [DATA_WIDTH-1:0]    write_data_1,
   output logic                     grant_1,
   output logic                     read_valid_1,
   output logic [DATA_WIDTH-1:0]    read_data_1,

   output logic [ADDRESS_WIDTH-1:0] address,
   output logic                     write_enable,
   output logic [DATA_WIDTH-1:0]    write_data,
   input  logic [DATA_WIDTH-1:0]    read_data,
   output logic                     busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

   state_t state;
   logic   last_granted;
   logic   winner;
   logic   pick;

   // Contention goes to whoever did not win last; otherwise the sole requester wins.
   assign pick = (request_0 && request_1) ? ~last_granted : request_1;

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         last_granted <= 1'b1;
         winner       <= 1'b0;
         grant_0      <= 1'b0;
         grant_1      <= 1'b0;
         read_valid_0 <= 1'b0;
         read_valid_1 <= 1'b0;
         read_data_0  <= '0;
         read_data_1  <= '0;
         address      <= '0;
         write_enable <= 1'b0;
         write_data   <= '0;
         busy         <= 1'b0;
      end else begin
         grant_0      <= 1'b0;
         grant_1      <= 1'b0;
         read_valid_0 <= 1'b0;
         read_valid_1 <= 1'b0;
         unique case (state)
            IDLE: begin
               if (request_0 || request_1) begin
                  winner       <= pick;
                  last_granted <= pick;
                  grant_0      <= ~pick;
                  grant_1      <= pick;
                  address      <= pick ? address_1      : address_0;
                  write_enable <= pick ? write_enable_1 : write_enable_0;
                  write_data   <= pick ? write_data_1   : write_data_0;
                  busy         <= 1'b1;
                  state        <= ISSUE;
               end else begin
                  address      <= '0;
                  write_enable <= 1'b0;
                  write_data   <= '0;
                  busy         <= 1'b0;
               end
            end
            ISSUE: begin
               // write_enable still holds the latched write flag here
               write_enable <= 1'b0;
               write_data   <= '0;
               if (write_enable) begin
                  address <= '0;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  state   <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (winner) begin
                  read_data_1  <= read_data;
                  read_valid_1 <= 1'b1;
               end else begin
                  read_data_0  <= read_data;
                  read_valid_0 <= 1'b1;
               end
               address <= '0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed table, hand-written corner sequences and
// randomized traffic checked against a transaction-level timeline model.
module tb_bus_arbiter;
   localparam int unsigned AW = 8;
   localparam int unsigned DW = 8;
   localparam int unsigned N_RAND = 800;

   logic          clock = 1'b0;
   logic          reset;
   logic          request_0, request_1;
   logic [AW-1:0] address_0, address_1;
   logic          write_enable_0, write_enable_1;
   logic [DW-1:0] write_data_0, write_data_1;
   logic          grant_0, grant_1, read_valid_0, read_valid_1;
   logic [DW-1:0] read_data_0, read_data_1;
   logic [AW-1:0] address;
   logic          write_enable;
   logic [DW-1:0] write_data;
   logic [DW-1:0] read_data;
   logic          busy;

   logic [7:0] mem [256];
   assign read_data = mem[address];

   always #5 clock = ~clock;

   bus_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clock(clock), .reset(reset),
      .request_0(request_0), .address_0(address_0), .write_enable_0(write_enable_0),
      .write_data_0(write_data_0), .grant_0(grant_0), .read_valid_0(read_valid_0),
      .read_data_0(read_data_0),
      .request_1(request_1), .address_1(address_1), .write_enable_1(write_enable_1),
      .write_data_1(write_data_1), .grant_1(grant_1), .read_valid_1(read_valid_1),
      .read_data_1(read_data_1),
      .address(address), .write_enable(write_enable), .write_data(write_data),
      .read_data(read_data), .busy(busy)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      request_0 = 1'b0; address_0 = '0; write_enable_0 = 1'b0; write_data_0 = '0;
      request_1 = 1'b0; address_1 = '0; write_enable_1 = 1'b0; write_data_1 = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic drive0(input bit r, input logic [7:0] a, input bit w, input logic [7:0] d);
      request_0 = r; address_0 = a; write_enable_0 = w; write_data_0 = d;
   endtask

   task automatic drive1(input bit r, input logic [7:0] a, input bit w, input logic [7:0] d);
      request_1 = r; address_1 = a; write_enable_1 = w; write_data_1 = d;
   endtask

   typedef struct {
      bit         r0, r1;
      logic [7:0] a0, a1;
      bit         w0, w1;
      logic [7:0] d0, d1;
      bit         g0, g1;
      logic [7:0] ea;
      bit         ew;
      logic [7:0] ed, er;
   } vec_t;

   typedef struct {
      bit         g0, g1, rv0, rv1, we, busy, wd_chk;
      logic [7:0] addr, wd, rd;
   } exp_t;

   vec_t tbl [8];
   exp_t tl [1024];

   initial begin
      vec_t       v;
      int         q[$];
      int         c0, c1, k, w, free, last;
      bit         pend [2];
      bit         tw [2];
      logic [7:0] ta [2];
      logic [7:0] td [2];
      logic [7:0] hold [2];

      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[8'h34] = 8'h5C; mem[8'h05] = 8'hE1; mem[8'hFF] = 8'h3C;
      mem[8'h77] = 8'hC3; mem[8'h10] = 8'h6B;

      // r0 r1 a0 a1 w0 w1 d0 d1 | g0 g1 addr we wdata rdata ; round-robin from reset
      tbl[0] = '{1'b1,1'b0,8'h12,8'h00,1'b1,1'b0,8'hA5,8'h00, 1'b1,1'b0,8'h12,1'b1,8'hA5,8'h00};
      tbl[1] = '{1'b0,1'b1,8'h00,8'h34,1'b0,1'b0,8'h00,8'h99, 1'b0,1'b1,8'h34,1'b0,8'h99,8'h5C};
      tbl[2] = '{1'b1,1'b1,8'h01,8'h02,1'b1,1'b1,8'h11,8'h22, 1'b1,1'b0,8'h01,1'b1,8'h11,8'h00};
      tbl[3] = '{1'b1,1'b1,8'h03,8'h04,1'b0,1'b1,8'h33,8'h44, 1'b0,1'b1,8'h04,1'b1,8'h44,8'h00};
      tbl[4] = '{1'b1,1'b1,8'h05,8'h06,1'b0,1'b0,8'h55,8'h66, 1'b1,1'b0,8'h05,1'b0,8'h55,8'hE1};
      tbl[5] = '{1'b0,1'b1,8'h00,8'hFF,1'b0,1'b1,8'h00,8'hFF, 1'b0,1'b1,8'hFF,1'b1,8'hFF,8'h00};
      tbl[6] = '{1'b1,1'b0,8'h00,8'h00,1'b1,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h00,1'b1,8'h00,8'h00};
      tbl[7] = '{1'b1,1'b1,8'h08,8'hFF,1'b0,1'b0,8'h88,8'h77, 1'b0,1'b1,8'hFF,1'b0,8'h77,8'h3C};

      // Reset state
      do_reset();
      chk("rst_grant0", 32'(grant_0), 0);      chk("rst_grant1", 32'(grant_1), 0);
      chk("rst_rv0", 32'(read_valid_0), 0);    chk("rst_rv1", 32'(read_valid_1), 0);
      chk("rst_rd0", 32'(read_data_0), 0);     chk("rst_rd1", 32'(read_data_1), 0);
      chk("rst_addr", 32'(address), 0);        chk("rst_we", 32'(write_enable), 0);
      chk("rst_wd", 32'(write_data), 0);       chk("rst_busy", 32'(busy), 0);

      // Directed table
      for (int i = 0; i < 8; i++) begin
         v = tbl[i];
         drive0(v.r0, v.a0, v.w0, v.d0);
         drive1(v.r1, v.a1, v.w1, v.d1);
         @(negedge clock);
         chk($sformatf("row%0d_grant0", i), 32'(grant_0), 32'(v.g0));
         chk($sformatf("row%0d_grant1", i), 32'(grant_1), 32'(v.g1));
         chk($sformatf("row%0d_addr", i), 32'(address), 32'(v.ea));
         chk($sformatf("row%0d_we", i), 32'(write_enable), 32'(v.ew));
         chk($sformatf("row%0d_wd", i), 32'(write_data), 32'(v.ed));
         chk($sformatf("row%0d_busy", i), 32'(busy), 1);
         request_0 = 1'b0; request_1 = 1'b0;
         @(negedge clock);
         if (!v.ew) begin
            chk($sformatf("row%0d_cap_addr", i), 32'(address), 32'(v.ea));
            chk($sformatf("row%0d_cap_we", i), 32'(write_enable), 0);
            chk($sformatf("row%0d_cap_busy", i), 32'(busy), 1);
            chk($sformatf("row%0d_cap_rv", i), 32'({read_valid_1, read_valid_0}), 0);
            @(negedge clock);
            chk($sformatf("row%0d_rv0", i), 32'(read_valid_0), 32'(v.g0));
            chk($sformatf("row%0d_rv1", i), 32'(read_valid_1), 32'(v.g1));
            chk($sformatf("row%0d_rdata", i), 32'(v.g1 ? read_data_1 : read_data_0), 32'(v.er));
         end else begin
            chk($sformatf("row%0d_grants_off", i), 32'({grant_1, grant_0}), 0);
         end
         chk($sformatf("row%0d_idle_busy", i), 32'(busy), 0);
         chk($sformatf("row%0d_idle_addr", i), 32'(address), 0);
         chk($sformatf("row%0d_idle_we", i), 32'(write_enable), 0);
         chk($sformatf("row%0d_idle_wd", i), 32'(write_data), 0);
      end
      chk("hold_rd1", 32'(read_data_1), 32'h3C);
      chk("hold_rd0", 32'(read_data_0), 32'hE1);

      // Requester inputs change while the read is in flight
      drive0(1'b1, 8'h10, 1'b0, 8'h00);
      @(negedge clock);
      chk("chg_grant0", 32'(grant_0), 1);
      chk("chg_issue_addr", 32'(address), 32'h10);
      drive0(1'b0, 8'h20, 1'b1, 8'hEE);
      @(negedge clock);
      chk("chg_cap_addr", 32'(address), 32'h10);
      chk("chg_cap_we", 32'(write_enable), 0);
      @(negedge clock);
      chk("chg_rv0", 32'(read_valid_0), 1);
      chk("chg_rd0", 32'(read_data_0), 32'h6B);

      // Reset during CAPTURE aborts the read
      do_reset();
      drive0(1'b1, 8'h77, 1'b0, 8'h00);
      @(negedge clock);
      chk("abort_grant0", 32'(grant_0), 1);
      request_0 = 1'b0;
      @(negedge clock);
      chk("abort_cap_addr", 32'(address), 32'h77);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("abort_addr", 32'(address), 0);      chk("abort_we", 32'(write_enable), 0);
      chk("abort_wd", 32'(write_data), 0);     chk("abort_busy", 32'(busy), 0);
      chk("abort_grant", 32'({grant_1, grant_0}), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk($sformatf("abort_rv0_%0d", i), 32'(read_valid_0), 0);
         chk($sformatf("abort_rd0_%0d", i), 32'(read_data_0), 0);
         chk($sformatf("abort_busy_%0d", i), 32'(busy), 0);
      end
      drive1(1'b1, 8'h01, 1'b1, 8'h02);
      @(negedge clock);
      chk("abort_idle_grant1", 32'(grant_1), 1);
      request_1 = 1'b0;
      @(negedge clock);

      // Contention after reset, both reading
      do_reset();
      drive0(1'b1, 8'h05, 1'b0, 8'h00);
      drive1(1'b1, 8'h34, 1'b0, 8'h00);
      c0 = 0; c1 = 0; q.delete();
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (grant_0) begin q.push_back(0); request_0 = 1'b0; end
         if (grant_1) begin q.push_back(1); request_1 = 1'b0; end
         if (read_valid_0) c0++;
         if (read_valid_1) c1++;
      end
      chk("cont_ngrants", 32'(q.size()), 2);
      chk("cont_first", 32'((q.size() > 0) ? q[0] : 9), 0);
      chk("cont_second", 32'((q.size() > 1) ? q[1] : 9), 1);
      chk("cont_rv0_count", 32'(c0), 1);
      chk("cont_rv1_count", 32'(c1), 1);
      chk("cont_rd0", 32'(read_data_0), 32'hE1);
      chk("cont_rd1", 32'(read_data_1), 32'h5C);

      // Fairness with both requests held
      do_reset();
      drive0(1'b1, 8'h40, 1'b1, 8'h01);
      drive1(1'b1, 8'h41, 1'b1, 8'h02);
      q.delete();
      for (int i = 0; i < 40 && q.size() < 6; i++) begin
         @(negedge clock);
         if (grant_0 && grant_1) chk("fair_both_granted", 32'({grant_1, grant_0}), 1);
         if (grant_0) q.push_back(0);
         if (grant_1) q.push_back(1);
      end
      chk("fair_ngrants", 32'(q.size()), 6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("fair_grant%0d", i), 32'((q.size() > i) ? q[i] : 9), 32'(i % 2));
      idle_inputs();
      repeat (3) @(negedge clock);

      // Randomized traffic against a timeline of expected outputs
      for (int j = 0; j < 1024; j++) begin
         tl[j] = '{default: 0};
         tl[j].wd_chk = 1'b1;
      end
      do_reset();
      pend[0] = 1'b0; pend[1] = 1'b0;
      hold[0] = '0; hold[1] = '0;
      free = 0; last = 1;
      for (k = 0; k < int'(N_RAND); k++) begin
         if (tl[k].rv0) hold[0] = tl[k].rd;
         if (tl[k].rv1) hold[1] = tl[k].rd;
         chk($sformatf("rnd%0d_g0", k), 32'(grant_0), 32'(tl[k].g0));
         chk($sformatf("rnd%0d_g1", k), 32'(grant_1), 32'(tl[k].g1));
         chk($sformatf("rnd%0d_rv0", k), 32'(read_valid_0), 32'(tl[k].rv0));
         chk($sformatf("rnd%0d_rv1", k), 32'(read_valid_1), 32'(tl[k].rv1));
         chk($sformatf("rnd%0d_addr", k), 32'(address), 32'(tl[k].addr));
         chk($sformatf("rnd%0d_we", k), 32'(write_enable), 32'(tl[k].we));
         chk($sformatf("rnd%0d_busy", k), 32'(busy), 32'(tl[k].busy));
         if (tl[k].wd_chk) chk($sformatf("rnd%0d_wd", k), 32'(write_data), 32'(tl[k].wd));
         chk($sformatf("rnd%0d_rd0", k), 32'(read_data_0), 32'(hold[0]));
         chk($sformatf("rnd%0d_rd1", k), 32'(read_data_1), 32'(hold[1]));

         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && $urandom_range(2) == 0) begin
               pend[i] = 1'b1;
               ta[i] = 8'($urandom);
               tw[i] = 1'($urandom);
               td[i] = 8'($urandom);
            end else if (!pend[i]) begin
               ta[i] = 8'($urandom);
               td[i] = 8'($urandom);
            end
         end
         drive0(pend[0], ta[0], tw[0], td[0]);
         drive1(pend[1], ta[1], tw[1], td[1]);

         if (k + 1 >= free && (pend[0] || pend[1])) begin
            if (pend[0] && pend[1]) w = 1 - last;
            else                    w = pend[1] ? 1 : 0;
            last = w;
            if (w == 1) tl[k+1].g1 = 1'b1; else tl[k+1].g0 = 1'b1;
            tl[k+1].addr = ta[w];
            tl[k+1].we   = tw[w];
            tl[k+1].wd   = td[w];
            tl[k+1].busy = 1'b1;
            if (tw[w]) begin
               free = k + 3;
            end else begin
               tl[k+2].addr   = ta[w];
               tl[k+2].busy   = 1'b1;
               tl[k+2].wd_chk = 1'b0;
               if (w == 1) tl[k+3].rv1 = 1'b1; else tl[k+3].rv0 = 1'b1;
               tl[k+3].rd = mem[ta[w]];
               free = k + 4;
            end
            pend[w] = 1'b0;
         end
         @(negedge clock);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8, meaning the external and requester address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning the external and requester data width.
REQ-003 SHALL have one clock and a synchronous, active-high reset:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have these ports for each requester i in {0,1}:
- request_i  input  1  transaction request; held high until granted.
- address_i  input  ADDRESS_WIDTH  transaction address.
- write_enable_i  input  1  1=write, 0=read.
- write_data_i  input  DATA_WIDTH  write data.
- grant_i  output  1  one-cycle pulse; transaction accepted.
- read_valid_i  output  1  one-cycle pulse; read_data_i is valid.
- read_data_i  output  DATA_WIDTH  returned read data; held until that requester's next read completes.
REQ-005 SHALL have these external memory-bus ports:
- address  output  ADDRESS_WIDTH  memory address.
- write_enable  output  1  memory write strobe; also drives the pad output enables.
- write_data  output  DATA_WIDTH  memory write data.
- read_data  input  DATA_WIDTH  memory read data; valid one cycle after address is presented.
- busy  output  1  high in any state other than IDLE.

Function
REQ-006 SHALL implement the FSM states IDLE, ISSUE and CAPTURE.
REQ-007 In IDLE with at least one request_i high, SHALL at the clock edge:
- select the winner;
- latch the winner's address, write_enable and write_data;
- enter ISSUE.
REQ-008 grant_winner SHALL be high for exactly the first cycle of ISSUE; both grants SHALL be low otherwise.
REQ-009 When exactly one request is high, SHALL select that requester.
REQ-010 When both requests are high, SHALL select the requester that is not last_granted (round-robin).
REQ-011 SHALL update last_granted to the winner on every grant.
REQ-012 In ISSUE, SHALL drive address and write_data from the latched values, and write_enable from the latched write flag.
REQ-013 From ISSUE, a write SHALL return to IDLE; a read SHALL enter CAPTURE.
REQ-014 In CAPTURE, SHALL hold address and hold write_enable=0.
REQ-015 At the end of CAPTURE, SHALL register read_data into read_data_winner and return to IDLE.
REQ-016 SHALL pulse read_valid_winner high in the following IDLE cycle.
REQ-017 Latency from request sampled in IDLE:
- write: one ISSUE cycle; a new arbitration is possible 2 cycles after acceptance.
- read: read_valid 3 cycles after the sampling edge.
REQ-018 SHALL ignore requests while not in IDLE; a requester keeps request_i high and SHALL be served in a later IDLE.
REQ-019 In the IDLE cycle where read_valid pulses, new arbitration SHALL proceed concurrently.
REQ-020 SHALL drive address=0, write_enable=0 and write_data=0 whenever in IDLE.
REQ-021 Changes to requester inputs after grant SHALL NOT affect the in-flight transaction.
REQ-022 Address and data SHALL pass through unmodified at DATA_WIDTH and ADDRESS_WIDTH, with no arithmetic or wrap.

Reset
REQ-023 On reset, SHALL enter IDLE and clear to 0: grant_i, read_valid_i, read_data_i, address, write_enable, write_data and busy.
REQ-024 On reset, SHALL set last_granted=1 so that requester 0 wins the first contention.
REQ-025 Reset asserted in ISSUE or CAPTURE SHALL abort the transaction: no grant, no read_valid, no read_data update, and write_enable=0 from the next cycle.

Verification
REQ-026 Bench SHALL cover, one line per scenario:
- Single write: request_0 with address=0x12, write_enable_0=1, data=0xA5 -> grant_0 pulse; one cycle of address=0x12, write_enable=1, write_data=0xA5; busy for 1 cycle.
- Single read: request_1 with address=0x34, memory returns 0x5C -> read_valid_1 3 cycles after sampling; read_data_1=0x5C, held afterwards.
- Contention after reset: both requesting reads -> requester 0 granted first, requester 1 granted next; each read_valid_i pulses exactly once.
- Fairness: both requests held for 6 transactions -> grants alternate 0,1,0,1,0,1.
- Reset in CAPTURE during a read of 0x77 -> no read_valid; read_data_i stays 0; outputs 0; FSM in IDLE.
- Input change after grant: address_0 changed from 0x10 to 0x20 in ISSUE -> bus still shows 0x10.
